// File: rtl/perf_monitor.sv
// perf_monitor
//   Run-statistics producer at the writeback stage. While the program runs it
//   counts retired instructions, cycles, stall cycles and flush cycles. It
//   stops on a halt instruction, an idle timeout or cycle-counter saturation,
//   then freezes the counters. After stopping, a sequential restoring divider
//   computes CPI in fixed point as cycles * 2^CPI_FRAC / insts.
//
// Ports
//   clk, rst       clock; synchronous active-high reset
//   retire_valid   an instruction commits this cycle
//   retire_inst    encoding of the committing instruction
//   stall, flush   pipeline stall / branch flush this cycle
//   inst_count, cycle_count, stall_count, flush_count
//                  saturating run counters, frozen once stop is set
//   stop           program finished; sticky until rst
//   stop_cause     00 none, 01 halt, 10 idle timeout, 11 cycle saturation
//   cpi            Q(CNT_W-CPI_FRAC).CPI_FRAC cycles per instruction
//   cpi_valid      cpi is final; sticky until rst
module perf_monitor #(
  parameter int unsigned CNT_W        = 32,
  parameter logic [31:0] HALT_INST    = 32'hEAFFFFFE,
  parameter int unsigned IDLE_TIMEOUT = 64,
  parameter int unsigned CPI_FRAC     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             retire_valid,
  input  logic [31:0]      retire_inst,
  input  logic             stall,
  input  logic             flush,
  output logic [CNT_W-1:0] inst_count,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count,
  output logic             stop,
  output logic [1:0]       stop_cause,
  output logic [CNT_W-1:0] cpi,
  output logic             cpi_valid
);

  localparam int unsigned DIV_W  = CNT_W + CPI_FRAC;
  localparam int unsigned IDLE_W = $clog2(IDLE_TIMEOUT + 1);
  localparam int unsigned ITER_W = $clog2(DIV_W + 1);

  localparam logic [CNT_W-1:0]  ALL_ONES  = '1;
  localparam logic [CNT_W-1:0]  ONE       = CNT_W'(1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_TIMEOUT - 1);
  localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(DIV_W - 1);

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_DIVIDE = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t            state;
  logic [IDLE_W-1:0] idle_cnt;
  logic [DIV_W-1:0]  div_q;     // dividend bits shift out the top, quotient bits shift in
  logic [CNT_W-1:0]  div_r;     // partial remainder, always below the divisor
  logic [ITER_W-1:0] div_iter;

  // Counter values after the current RUN cycle is applied.
  logic [CNT_W-1:0] inst_nxt, cycle_nxt, stall_nxt, flush_nxt;
  logic             stop_now;
  logic [1:0]       cause_nxt;

  // One restoring-division step. The divisor is inst_count, already frozen.
  logic [CNT_W:0]   rem_shift, rem_diff;
  logic             q_bit;
  logic [DIV_W-1:0] q_nxt;
  logic [CNT_W-1:0] r_nxt, cpi_final;

  // Cycle count needs no saturation guard: reaching all-ones stops the run.
  assign cycle_nxt = cycle_count + ONE;
  assign inst_nxt  = (retire_valid && inst_count  != ALL_ONES) ? inst_count  + ONE : inst_count;
  assign stall_nxt = (stall        && stall_count != ALL_ONES) ? stall_count + ONE : stall_count;
  assign flush_nxt = (flush        && flush_count != ALL_ONES) ? flush_count + ONE : flush_count;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    cause_nxt = 2'b00;
    if (retire_valid && retire_inst == HALT_INST)
      cause_nxt = 2'b01;
    else if (!retire_valid && idle_cnt == IDLE_LAST)
      cause_nxt = 2'b10;
    else if (cycle_count == ALL_ONES - ONE)
      cause_nxt = 2'b11;
  end

  assign stop_now = (cause_nxt != 2'b00);

  assign rem_shift = {div_r, div_q[DIV_W-1]};
  assign rem_diff  = rem_shift - {1'b0, inst_count};
  assign q_bit     = (rem_shift >= {1'b0, inst_count});
  assign r_nxt     = q_bit ? rem_diff[CNT_W-1:0] : rem_shift[CNT_W-1:0];
  assign q_nxt     = {div_q[DIV_W-2:0], q_bit};
  // Quotient bits above CNT_W mean the result does not fit: saturate.
  assign cpi_final = (|q_nxt[DIV_W-1:CNT_W]) ? ALL_ONES : q_nxt[CNT_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
      state       <= S_RUN;
      idle_cnt    <= '0;
      div_q       <= '0;
      div_r       <= '0;
      div_iter    <= '0;
      inst_count  <= '0;
      cycle_count <= '0;
      stall_count <= '0;
      flush_count <= '0;
      stop        <= 1'b0;
      stop_cause  <= 2'b00;
      cpi         <= '0;
      cpi_valid   <= 1'b0;
    end else begin
      case (state)
        S_RUN: begin
          inst_count  <= inst_nxt;
          cycle_count <= cycle_nxt;
          stall_count <= stall_nxt;
          flush_count <= flush_nxt;
          idle_cnt    <= retire_valid ? '0 : idle_cnt + IDLE_W'(1);
          if (stop_now) begin
            stop       <= 1'b1;
            stop_cause <= cause_nxt;
            div_q      <= DIV_W'(cycle_nxt) << CPI_FRAC;
            div_r      <= '0;
            div_iter   <= '0;
            // With no instructions retired there is nothing to divide.
            state      <= (inst_nxt == '0) ? S_DONE : S_DIVIDE;
          end
        end
        S_DIVIDE: begin
          div_q    <= q_nxt;
          div_r    <= r_nxt;
          div_iter <= div_iter + ITER_W'(1);
          if (div_iter == ITER_LAST) begin
            cpi       <= cpi_final;
            cpi_valid <= 1'b1;
            state     <= S_DONE;
          end
        end
        S_DONE: begin
          // Only reached without a valid cpi on the zero-instruction path.
          if (!cpi_valid) begin
            cpi       <= ALL_ONES;
            cpi_valid <= 1'b1;
          end
        end
        default: state <= S_RUN;
      endcase
    end
  end

endmodule
